// File: rtl/fpu_defs.sv
// fpu_defs: shared FPU widths, flag layout and result/flag record types.
package fpu_defs;

    localparam int C_OP   = 32;
    localparam int C_FLAG = 6;

    localparam int C_FLAG_OF   = 0;
    localparam int C_FLAG_UF   = 1;
    localparam int C_FLAG_ZERO = 2;
    localparam int C_FLAG_IX   = 3;
    localparam int C_FLAG_IV   = 4;
    localparam int C_FLAG_INF  = 5;

    // Member order places each flag at its C_FLAG_* bit index.
    typedef struct packed {
        logic Inf;
        logic IV;
        logic IX;
        logic Zero;
        logic UF;
        logic OF;
    } fpu_flags_t;

    typedef struct packed {
        logic [C_OP-1:0] Result;
        fpu_flags_t      Flags;
    } fpu_result_t;

    // Accrued-exception view of a flag set: {IV, OF, UF, IX}; Zero and Inf never accrue.
    function automatic logic [3:0] sticky_bits(fpu_flags_t f);
        return {f.IV, f.OF, f.UF, f.IX};
    endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: in-order storage for FPU results; pointers wrap modulo C_DEPTH
// so any depth works, and a pop while empty is ignored.
module fpu_result_fifo
    import fpu_defs::*;
#(
    parameter  int C_DEPTH = 4,
    localparam int C_CW    = $clog2(C_DEPTH + 1)
) (
    input  logic            Clk_CI,
    input  logic            Rst_RI,
    input  logic            Push_SI,
    input  fpu_result_t     Data_DI,
    input  logic            Pop_SI,
    output fpu_result_t     Data_DO,
    output logic            Valid_SO,
    output logic [C_CW-1:0] Count_SO
);

    localparam int C_PW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

    fpu_result_t     mem_D [C_DEPTH];
    logic [C_PW-1:0] rd_ptr_DP, wr_ptr_DP;
    logic [C_CW-1:0] count_DP;
    logic            pop, full;

    function automatic logic [C_PW-1:0] ptr_inc(logic [C_PW-1:0] p);
        return (p == C_PW'(C_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign Valid_SO = (count_DP != '0);
    assign full     = (count_DP == C_CW'(C_DEPTH));
    assign pop      = Pop_SI & Valid_SO;
    assign Count_SO = count_DP;
    assign Data_DO  = Valid_SO ? mem_D[rd_ptr_DP] : '0;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            rd_ptr_DP <= '0;
            wr_ptr_DP <= '0;
            count_DP  <= '0;
        end else begin
            if (Push_SI) wr_ptr_DP <= ptr_inc(wr_ptr_DP);
            if (pop) rd_ptr_DP <= ptr_inc(rd_ptr_DP);
            count_DP <= count_DP + C_CW'(Push_SI) - C_CW'(pop);
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Push_SI) mem_D[wr_ptr_DP] <= Data_DI;
    end

    // Credit-based stalling upstream must make this unreachable.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RI) assert (!(Push_SI && full)) else $error("push into full result fifo");
    end

endmodule

// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: captures FPU results as they leave the pipeline, queues them for
// writeback, stalls the FPU on credits so every result has a slot, and accrues fflags.
module fpu_result_buffer
    import fpu_defs::*;
#(
    parameter  int C_LATENCY = 2,
    parameter  int C_DEPTH   = 4,
    localparam int C_CW      = $clog2(C_DEPTH + 1)
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              Issue_SI,
    input  logic [C_OP-1:0]   Result_DI,
    input  logic              OF_SI,
    input  logic              UF_SI,
    input  logic              Zero_SI,
    input  logic              IX_SI,
    input  logic              IV_SI,
    input  logic              Inf_SI,
    output logic              Stall_SO,
    output logic              Valid_SO,
    input  logic              Ready_SI,
    output logic [C_OP-1:0]   Result_DO,
    output logic [C_FLAG-1:0] Flags_DO,
    output logic [3:0]        Sticky_DO,
    input  logic              ClearSticky_SI,
    output logic [C_CW-1:0]   Count_SO
);

    if (C_DEPTH <= C_LATENCY) begin : g_depth_check
        $error("fpu_result_buffer: C_DEPTH must exceed C_LATENCY");
    end

    logic [C_LATENCY-1:0] tracker_DP, tracker_DN;
    logic [3:0]           sticky_DP, sticky_DN;
    logic                 accept, push;
    int                   inflight;
    fpu_result_t          in_D, head_D;

    // Stall depends only on registered occupancy and in-flight credits.
    always_comb begin
        inflight   = $countones(tracker_DP);
        Stall_SO   = (int'(Count_SO) + inflight) >= C_DEPTH;
        accept     = Issue_SI & ~Stall_SO;
        push       = tracker_DP[C_LATENCY-1] & ~Stall_SO;
        tracker_DN = Stall_SO ? tracker_DP : ((tracker_DP << 1) | C_LATENCY'(accept));
        in_D       = {Result_DI, Inf_SI, IV_SI, IX_SI, Zero_SI, UF_SI, OF_SI};
        sticky_DN  = (ClearSticky_SI ? 4'b0 : sticky_DP) | (push ? sticky_bits(in_D.Flags) : 4'b0);
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            tracker_DP <= '0;
            sticky_DP  <= '0;
        end else begin
            tracker_DP <= tracker_DN;
            sticky_DP  <= sticky_DN;
        end
    end

    fpu_result_fifo #(
        .C_DEPTH (C_DEPTH)
    ) i_fifo (
        .Clk_CI   (Clk_CI),
        .Rst_RI   (Rst_RI),
        .Push_SI  (push),
        .Data_DI  (in_D),
        .Pop_SI   (Ready_SI),
        .Data_DO  (head_D),
        .Valid_SO (Valid_SO),
        .Count_SO (Count_SO)
    );

    assign Result_DO = head_D.Result;
    assign Flags_DO  = head_D.Flags;
    assign Sticky_DO = sticky_DP;

endmodule
